// File: rtl/pixel_to_fifo_packer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_to_fifo_packer
// Purpose  : Packs an Avalon-ST pixel stream (one PIXEL_W symbol per beat)
//            into PIXEL_W*PIXELS_PER_WORD wide Avalon-ST words for the frame
//            FIFO. The first pixel of a word lands in the most significant
//            lane. sop/eop framing is carried through, and out_empty reports
//            the unused low-order lanes of the final word. Pixels arriving
//            outside a packet are dropped, and framing errors raise a sticky
//            flag.
// Ports    : clk, reset (async, active-high)
//            in_ready/in_valid/in_data/in_startofpacket/in_endofpacket - sink
//            out_ready/out_valid/out_data/out_startofpacket/
//            out_endofpacket/out_empty                                 - source
//            clear_err  - synchronous clear of err_framing
//            err_framing - sticky framing-error flag
// Revision : 1.0 - initial release
// ============================================================================
module pixel_to_fifo_packer #(
    parameter int PIXEL_W         = 8,
    parameter int PIXELS_PER_WORD = 4,
    parameter int EMPTY_W         = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               in_ready,
    input  logic                               in_valid,
    input  logic [PIXEL_W-1:0]                 in_data,
    input  logic                               in_startofpacket,
    input  logic                               in_endofpacket,
    input  logic                               out_ready,
    output logic                               out_valid,
    output logic [PIXEL_W*PIXELS_PER_WORD-1:0] out_data,
    output logic                               out_startofpacket,
    output logic                               out_endofpacket,
    output logic [EMPTY_W-1:0]                 out_empty,
    input  logic                               clear_err,
    output logic                               err_framing
);

    localparam int                 c_word_w    = PIXEL_W * PIXELS_PER_WORD;
    localparam logic [EMPTY_W-1:0] c_last_lane = EMPTY_W'(PIXELS_PER_WORD - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } state_t;

    state_t                r_state;
    logic [EMPTY_W-1:0]    r_lane;
    logic [c_word_w-1:0]   r_accum;
    logic                  r_acc_sop;

    logic                  r_out_valid;
    logic [c_word_w-1:0]   r_out_data;
    logic                  r_out_sop;
    logic                  r_out_eop;
    logic [EMPTY_W-1:0]    r_out_empty;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_take;
    logic                  w_complete;
    logic                  w_err_set;
    logic [EMPTY_W-1:0]    w_lane_eff;
    logic [c_word_w-1:0]   w_word;
    logic                  w_sop_flag;

    // The output register may be refilled in the very cycle it is drained,
    // so the sink is ready whenever the held word is leaving or absent.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        // A sop always restarts packing at lane 0 from an empty word; this
        // both starts a packet from IDLE and discards a partial word when a
        // new packet interrupts the current one.
        w_lane_eff = in_startofpacket ? '0 : r_lane;
        w_word     = in_startofpacket ? '0 : r_accum;
        for (int k = 0; k < PIXELS_PER_WORD; k++) begin
            if (w_lane_eff == EMPTY_W'(k)) begin
                w_word[c_word_w-1-k*PIXEL_W -: PIXEL_W] = in_data;
            end
        end
        w_sop_flag = in_startofpacket || r_acc_sop;
        w_take     = w_accept && ((r_state == S_IN_PKT) || in_startofpacket);
        w_complete = w_take && ((w_lane_eff == c_last_lane) || in_endofpacket);
        w_err_set  = w_accept && ((r_state == S_IDLE) ? !in_startofpacket
                                                      : in_startofpacket);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lane      <= '0;
            r_accum     <= '0;
            r_acc_sop   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_complete) begin
                // Load replaces any word being transferred this cycle, so
                // out_valid stays high without a bubble.
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_sop   <= w_sop_flag;
                r_out_eop   <= in_endofpacket;
                r_out_empty <= in_endofpacket ? (c_last_lane - w_lane_eff) : '0;
                r_lane      <= '0;
                r_accum     <= '0;
                r_acc_sop   <= 1'b0;
                r_state     <= in_endofpacket ? S_IDLE : S_IN_PKT;
            end else begin
                if (w_take) begin
                    r_accum   <= w_word;
                    r_lane    <= w_lane_eff + EMPTY_W'(1);
                    r_acc_sop <= w_sop_flag;
                    r_state   <= S_IN_PKT;
                end
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end

            // A new error in the same cycle as a clear takes priority.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (clear_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_empty         = r_out_empty;
    assign err_framing       = r_err;

endmodule
`default_nettype wire
